// File: rtl/spike_map_collector_if.sv
// Port bundle for spike_map_collector: the packet input port and the row output port.
// Handshake (both ports): a word moves on a rising edge where valid && ready; once valid is raised its data holds stable until that edge.
interface spike_map_collector_if #(
  parameter int WIDTH = 64,
  parameter int COLS  = 21
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_packet;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_row_idx;
  logic [COLS-1:0]  out_row;
  logic [7:0]       out_timestep;

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_row_idx, out_row, out_timestep
  );

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_row_idx, out_row, out_timestep
  );
endinterface

// File: rtl/spike_map_collector.sv
// Collects output-spike packets into a ROWS x COLS bitmap per timestep, then drains
// the bitmap row by row once every adder has sent its done marker.
module spike_map_collector #(
  parameter logic [3:0] MY_ADDRESS    = 4'b1010,
  parameter int         NUM_ADDERS    = 7,
  parameter int         ROWS          = 21,
  parameter int         COLS          = 21,
  parameter int         NUM_TIMESTEPS = 10,
  parameter int         WIDTH         = 64,
  localparam int        CNT_W         = $clog2(NUM_ADDERS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  spike_map_collector_if.slave bus,
  output logic [8:0]        spike_count,
  output logic              ts_done,
  output logic              all_done,
  output logic              err_pkt,
  output logic [1:0]        o_dbg_state,
  output logic [CNT_W-1:0]  o_dbg_done_cnt
);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_DRAIN    = 2'd1,
    S_CLEAR    = 2'd2,
    S_FINISHED = 2'd3
  } state_t;

  localparam logic [4:0]       LP_ROWS     = 5'(ROWS);
  localparam logic [4:0]       LP_COLS     = 5'(COLS);
  localparam logic [4:0]       LP_LAST_ROW = 5'(ROWS - 1);
  localparam logic [8:0]       LP_MAX_CNT  = 9'(ROWS * COLS);
  localparam logic [CNT_W-1:0] LP_ADDERS   = CNT_W'(NUM_ADDERS);
  localparam logic [7:0]       LP_TS       = 8'(NUM_TIMESTEPS);

  state_t           r_state;
  logic [COLS-1:0]  r_map [ROWS];
  logic [15:0]      r_done_mask;
  logic [CNT_W-1:0] r_done_cnt;
  logic [7:0]       r_timestep;
  logic [8:0]       r_spike_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [4:0]       r_out_row_idx;
  logic [COLS-1:0]  r_out_row;
  logic [7:0]       r_out_timestep;
  logic             r_ts_done;
  logic             r_all_done;
  logic             r_err_pkt;

  logic       w_accept;
  logic [3:0] w_dest;
  logic [3:0] w_src;
  logic [1:0] w_type;
  logic [9:0] w_payload;
  logic [4:0] w_x;
  logic [4:0] w_y;
  logic       w_pkt_ok;
  logic       w_is_done;
  logic       w_in_range;
  logic       w_unused_bits;

  assign w_accept      = bus.in_valid && r_in_ready;
  assign w_dest        = bus.in_packet[WIDTH-1 -: 4];
  assign w_src         = bus.in_packet[WIDTH-5 -: 4];
  assign w_type        = bus.in_packet[WIDTH-9 -: 2];
  assign w_payload     = bus.in_packet[9:0];
  assign w_x           = w_payload[9:5];
  assign w_y           = w_payload[4:0];
  assign w_pkt_ok      = (w_dest == MY_ADDRESS) && (w_type == 2'b11);
  assign w_is_done     = (w_payload == 10'h3FF);
  assign w_in_range    = (w_x < LP_ROWS) && (w_y < LP_COLS);
  // The zero-filled middle of the packet carries nothing and is not checked.
  assign w_unused_bits = ^bus.in_packet[WIDTH-11:10];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_COLLECT;
      r_map          <= '{default: '0};
      r_done_mask    <= '0;
      r_done_cnt     <= '0;
      r_timestep     <= '0;
      r_spike_count  <= '0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_row_idx  <= '0;
      r_out_row      <= '0;
      r_out_timestep <= '0;
      r_ts_done      <= 1'b0;
      r_all_done     <= 1'b0;
      r_err_pkt      <= 1'b0;
    end else begin
      r_ts_done <= 1'b0;
      r_err_pkt <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            if (!w_pkt_ok) begin
              r_err_pkt <= 1'b1;
            end else if (w_is_done) begin
              if (r_done_mask[w_src]) begin
                r_err_pkt <= 1'b1;
              end else begin
                r_done_mask[w_src] <= 1'b1;
                r_done_cnt         <= r_done_cnt + 1'b1;
                // The completing marker closes the port at once so nothing slips in behind it.
                if (r_done_cnt + 1'b1 == LP_ADDERS) r_in_ready <= 1'b0;
              end
            end else if (!w_in_range) begin
              r_err_pkt <= 1'b1;
            end else if (!r_map[w_x][w_y]) begin
              r_map[w_x][w_y] <= 1'b1;
              if (r_spike_count != LP_MAX_CNT) r_spike_count <= r_spike_count + 9'd1;
            end
          end
          if (r_done_cnt == LP_ADDERS) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (!r_out_valid) begin
            r_out_valid    <= 1'b1;
            r_out_row      <= r_map[r_out_row_idx];
            r_out_timestep <= r_timestep;
          end else if (bus.out_ready) begin
            if (r_out_row_idx == LP_LAST_ROW) begin
              r_out_valid <= 1'b0;
              r_state     <= S_CLEAR;
            end else begin
              r_out_row_idx <= r_out_row_idx + 5'd1;
              r_out_row     <= r_map[r_out_row_idx + 5'd1];
            end
          end
        end

        S_CLEAR: begin
          r_map         <= '{default: '0};
          r_done_mask   <= '0;
          r_done_cnt    <= '0;
          r_spike_count <= '0;
          r_out_row_idx <= '0;
          r_out_row     <= '0;
          r_ts_done     <= 1'b1;
          r_timestep    <= r_timestep + 8'd1;
          if (r_timestep + 8'd1 == LP_TS) begin
            r_state    <= S_FINISHED;
            r_all_done <= 1'b1;
          end else begin
            r_state    <= S_COLLECT;
            r_in_ready <= 1'b1;
          end
        end

        S_FINISHED: begin
          r_in_ready <= 1'b0;
        end

        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_row_idx  = r_out_row_idx;
  assign bus.out_row      = r_out_row;
  assign bus.out_timestep = r_out_timestep;
  assign spike_count      = r_spike_count;
  assign ts_done          = r_ts_done;
  assign all_done         = r_all_done;
  assign err_pkt          = r_err_pkt;
  assign o_dbg_state      = r_state;
  assign o_dbg_done_cnt   = r_done_cnt;

endmodule

// File: doc/spike_map_collector.md
Name: spike_map_collector

Overview:
- Memory-side receiver for the output-spike packets that the partial-sum adders emit.
- Accepts 64-bit packets on a valid/ready port and filters them by destination and type.
- Sets one bit per spike in a ROWS x COLS spike bitmap. When every adder has sent its "done" marker, the timestep's bitmap is drained row by row to the downstream memory writer. The map is then cleared and collection of the next timestep begins.

Parameters:
- MY_ADDRESS, 4'b1010, destination address this block accepts (packet[63:60]).
- NUM_ADDERS, 7, number of distinct adder sources whose done marker closes a timestep.
- ROWS, 21, spike map rows (x coordinate range 0..ROWS-1).
- COLS, 21, spike map columns (y coordinate range 0..COLS-1).
- NUM_TIMESTEPS, 10, timesteps processed before all_done.
- WIDTH, 64, packet width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  packet valid.
- in_ready  output  1  block can accept a packet.
- in_packet  input  WIDTH  {dest[63:60], src[59:56], type[55:54], zeros[53:10], payload[9:0]}.
- out_valid  output  1  row data valid.
- out_ready  input  1  downstream accepts row.
- out_row_idx  output  5  row index being presented.
- out_row  output  COLS  spike bits of row; bit y = spike at (row, y).
- out_timestep  output  8  timestep the drained map belongs to.
- spike_count  output  9  distinct spikes recorded in the current timestep.
- ts_done  output  1  one-cycle pulse on completion of a timestep drain.
- all_done  output  1  level; high after NUM_TIMESTEPS timesteps.
- err_pkt  output  1  one-cycle pulse when an accepted packet is dropped as malformed.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - State COLLECT; map all zeros; done_mask 0; done_cnt 0.
  - timestep 0; spike_count 0.
  - in_ready 1; out_valid 0; out_row_idx 0; out_row 0; out_timestep 0.
  - ts_done 0; all_done 0; err_pkt 0.
  - Reset mid-DRAIN discards the map and returns to COLLECT, timestep 0.
- Handshake (both ports):
  - Transfer occurs when valid && ready on a rising edge.
  - out_valid, once raised, holds with stable out_row/out_row_idx/out_timestep until out_ready.
- State COLLECT:
  - in_ready = 1.
  - Accepted packet with dest != MY_ADDRESS or type != 2'b11: dropped, err_pkt pulses the next cycle.
  - payload == 10'h3FF (done marker): if done_mask[src] is 0, set it and increment done_cnt. If already set (duplicate), drop and pulse err_pkt.
  - Otherwise x = payload[9:5], y = payload[4:0].
    - If x >= ROWS or y >= COLS: drop, err_pkt.
    - Else set map[x][y]; spike_count increments only if the bit was previously 0. Duplicate spikes are idempotent, with no error.
  - Result is visible one cycle after acceptance.
  - When done_cnt reaches NUM_ADDERS (registered), move to DRAIN next cycle. The packet that completes the count is the last accepted in this timestep.
- State DRAIN:
  - in_ready = 0.
  - Present rows 0..ROWS-1 in order: out_valid = 1, out_row = map[row], out_timestep = timestep.
  - Row advances on each accepted transfer. With out_ready held high, one row per cycle, so ROWS cycles.
  - After row ROWS-1 is accepted, go to CLEAR.
- State CLEAR (1 cycle):
  - in_ready = 0, out_valid = 0.
  - Zero the map, done_mask, done_cnt and spike_count.
  - Pulse ts_done; increment timestep.
  - If the new timestep == NUM_TIMESTEPS, go to FINISHED, else go to COLLECT.
- State FINISHED:
  - in_ready = 0, all_done = 1.
  - Held until reset.
- Latency: from acceptance of the final done marker to the first out_valid is 2 cycles.
- spike_count saturates at ROWS*COLS. It is only sampled meaningfully during DRAIN.

Test Plan:
- Reset, then spikes at (0,6), (20,20), (5,13) plus done markers from src 1..7 with out_ready = 1.
  - Required: rows 0, 5, 20 show bits 6, 13, 20 respectively; other rows are 0.
  - Required: spike_count = 3 during DRAIN, ts_done pulse, timestep = 1.
- Send spike (3,4) twice, then complete the timestep.
  - Required: spike_count = 1, row 3 = 21'h10, no err_pkt.
- Send a done marker from src 2 twice.
  - Required: err_pkt on the second; done_cnt stays until all 7 distinct sources have sent.
  - Required: DRAIN begins exactly 2 cycles after the 7th distinct done.
- Send packets with dest 4'b0000, type 2'b10, and coordinates (21,0) and (0,25).
  - Required: each is dropped with err_pkt, the map is unchanged, in_ready stays 1.
- During DRAIN, toggle out_ready 1010...
  - Required: out_row and out_row_idx stay stable while stalled; rows emitted 0..20 with none skipped or repeated; in_packet is ignored (in_ready = 0).
- Run NUM_TIMESTEPS = 10 timesteps, and separately assert reset at row 10 of a DRAIN.
  - Required: all_done rises after the 10th CLEAR and in_ready stays 0.
  - Required: the reset returns to COLLECT with timestep 0 and an empty map on the next cycle.
